// File: rtl/axis_video_frame_checker_pkg.sv
// Shared constants and types for the AXI-Stream video frame checker.
// Error-flag bit positions, FSM state encoding and checksum width.
package axi_stream_video_checker_pkg;

  localparam int ERR_W          = 5;
  localparam int ERR_EARLY_EOL  = 0;
  localparam int ERR_MISS_EOL   = 1;
  localparam int ERR_EARLY_SOF  = 2;
  localparam int ERR_ORPHAN     = 3;
  localparam int ERR_TLAST_NOFR = 4;

  localparam int CSUM_W = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/axis_video_frame_checker_if.sv
// AXI-Stream video link bundle (TDATA/TVALID/TREADY/TLAST/TUSER).
// The monitor modport observes every signal without driving any.
interface axis_video_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic              tuser;

  modport master (
    output tdata, tvalid, tlast, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tlast, tuser,
    output tready
  );

  modport monitor (
    input tdata, tvalid, tready, tlast, tuser
  );
endinterface

// File: rtl/axis_video_frame_checker_pixel_sum.sv
// Combinational sum of all pixels in one beat, each pixel
// zero-extended or truncated to the checksum width.
module axis_video_pixel_sum
  import axi_stream_video_checker_pkg::*;
#(
  parameter int PIXEL_PER_CLK  = 1,
  parameter int BITS_PER_PIXEL = 32
) (
  input  logic [BITS_PER_PIXEL*PIXEL_PER_CLK-1:0] data,
  output logic [CSUM_W-1:0]                       sum
);

  always_comb begin
    sum = '0;
    for (int i = 0; i < PIXEL_PER_CLK; i++) begin
      sum = sum + CSUM_W'(data[i*BITS_PER_PIXEL +: BITS_PER_PIXEL]);
    end
  end

endmodule

// File: rtl/axis_video_frame_checker.sv
// Passive AXI-Stream video frame geometry checker.
// Optional frame checksum: define AXIS_VIDEO_CHECKER_CHECKSUM_EN.
module axis_video_frame_checker
  import axi_stream_video_checker_pkg::*;
#(
  parameter int IMAGE_WIDTH    = 960,
  parameter int IMAGE_HEIGHT   = 540,
  parameter int PIXEL_PER_CLK  = 1,
  parameter int BITS_PER_PIXEL = 32,
  parameter int FRAME_CNT_W    = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  axis_video_if.monitor                   s_axis_video_in,
  input  logic                            err_clear,
  output logic [$clog2(IMAGE_WIDTH)-1:0]  pos_x,
  output logic [$clog2(IMAGE_HEIGHT)-1:0] pos_y,
  output logic                            in_frame,
  output logic                            frame_done,
  output logic [FRAME_CNT_W-1:0]          frame_count,
`ifdef AXIS_VIDEO_CHECKER_CHECKSUM_EN
  output logic [CSUM_W-1:0]               frame_checksum,
`endif
  output logic [ERR_W-1:0]                err_flags
);

  localparam int XW = $clog2(IMAGE_WIDTH);
  localparam int YW = $clog2(IMAGE_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMAGE_WIDTH - PIXEL_PER_CLK);
  localparam logic [XW-1:0] X_STEP = XW'(PIXEL_PER_CLK);
  localparam logic [YW-1:0] Y_LAST = YW'(IMAGE_HEIGHT - 1);

  state_e                 state_q, state_d;
  logic [XW-1:0]          x_q, x_d, cur_x;
  logic [YW-1:0]          y_q, y_d, cur_y;
  logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0]       err_q, err_d, new_err;
  logic                   done_q, done_d;
  logic                   beat, accept, sof, at_eol, line_end;

  assign beat = s_axis_video_in.tvalid & s_axis_video_in.tready;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    new_err  = '0;
    accept   = 1'b0;
    sof      = 1'b0;
    cur_x    = x_q;
    cur_y    = y_q;
    at_eol   = 1'b0;
    line_end = 1'b0;
    if (beat) begin
      unique case (state_q)
        IDLE: begin
          if (s_axis_video_in.tuser) begin
            accept = 1'b1;
            sof    = 1'b1;
          end else begin
            new_err[ERR_ORPHAN]     = 1'b1;
            new_err[ERR_TLAST_NOFR] = s_axis_video_in.tlast;
          end
        end
        ACTIVE: begin
          accept = 1'b1;
          sof    = s_axis_video_in.tuser;
          new_err[ERR_EARLY_SOF] = s_axis_video_in.tuser &
                                   ((x_q != '0) | (y_q != '0));
        end
        default: ;
      endcase
    end
    if (accept) begin
      // A SOF beat (fresh or resync) is pixel (0,0) of a new frame.
      cur_x    = sof ? '0 : x_q;
      cur_y    = sof ? '0 : y_q;
      at_eol   = (cur_x == X_LAST);
      line_end = s_axis_video_in.tlast | at_eol;
      new_err[ERR_EARLY_EOL] = s_axis_video_in.tlast & ~at_eol;
      new_err[ERR_MISS_EOL]  = at_eol & ~s_axis_video_in.tlast;
      state_d = ACTIVE;
      x_d     = cur_x + X_STEP;
      y_d     = cur_y;
      if (line_end) begin
        x_d = '0;
        if (cur_y == Y_LAST) begin
          y_d     = '0;
          done_d  = 1'b1;
          cnt_d   = cnt_q + FRAME_CNT_W'(1);
          state_d = IDLE;
        end else begin
          y_d = cur_y + YW'(1);
        end
      end
    end
    // A new error outranks a simultaneous clear.
    err_d = (err_clear ? '0 : err_q) | new_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign pos_x       = x_q;
  assign pos_y       = y_q;
  assign in_frame    = (state_q == ACTIVE);
  assign frame_done  = done_q;
  assign frame_count = cnt_q;
  assign err_flags   = err_q;

`ifdef AXIS_VIDEO_CHECKER_CHECKSUM_EN
  logic [CSUM_W-1:0] beat_sum, acc_q, acc_d, csum_q, csum_d;

  axis_video_pixel_sum #(
    .PIXEL_PER_CLK  (PIXEL_PER_CLK),
    .BITS_PER_PIXEL (BITS_PER_PIXEL)
  ) u_pixel_sum (
    .data (s_axis_video_in.tdata),
    .sum  (beat_sum)
  );

  always_comb begin
    acc_d  = acc_q;
    csum_d = csum_q;
    if (accept) begin
      acc_d = sof ? beat_sum : acc_q + beat_sum;
    end
    if (done_d) begin
      csum_d = acc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      csum_q <= '0;
    end else begin
      acc_q  <= acc_d;
      csum_q <= csum_d;
    end
  end

  assign frame_checksum = csum_q;
`else
  logic unused_tdata;
  assign unused_tdata = ^s_axis_video_in.tdata;
`endif

endmodule

// File: tb/tb_axis_video_frame_checker.sv
// Directed self-checking bench for axis_video_frame_checker.
// Geometry W=8, H=4, PPC=2, BPP=32; tready high unless noted.
module tb_axis_video_frame_checker;

  localparam int W   = 8;
  localparam int H   = 4;
  localparam int PPC = 2;
  localparam int BPP = 32;
  localparam logic [63:0] PIX = {2{32'h01020304}};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        err_clear = 1'b0;
  logic [2:0]  pos_x;
  logic [1:0]  pos_y;
  logic        in_frame;
  logic        frame_done;
  logic [15:0] frame_count;
  logic [4:0]  err_flags;
`ifdef AXIS_VIDEO_CHECKER_CHECKSUM_EN
  logic [31:0] frame_checksum;
`endif

  int errors   = 0;
  int checks   = 0;
  int done_cnt = 0;
  int base;

  axis_video_if #(.DATA_W(BPP*PPC)) vif();

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

  axis_video_frame_checker #(
    .IMAGE_WIDTH    (W),
    .IMAGE_HEIGHT   (H),
    .PIXEL_PER_CLK  (PPC),
    .BITS_PER_PIXEL (BPP),
    .FRAME_CNT_W    (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .s_axis_video_in (vif),
    .err_clear       (err_clear),
    .pos_x           (pos_x),
    .pos_y           (pos_y),
    .in_frame        (in_frame),
    .frame_done      (frame_done),
    .frame_count     (frame_count),
`ifdef AXIS_VIDEO_CHECKER_CHECKSUM_EN
    .frame_checksum  (frame_checksum),
`endif
    .err_flags       (err_flags)
  );

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  // gap idle cycles precede the beat so outputs after return reflect it
  task automatic send(input logic u, input logic l, input int gap);
    repeat (gap) idle_cycle();
    vif.tvalid = 1'b1;
    vif.tuser  = u;
    vif.tlast  = l;
    vif.tdata  = PIX;
    @(posedge clk); #1;
    vif.tvalid = 1'b0;
    vif.tuser  = 1'b0;
    vif.tlast  = 1'b0;
  endtask

  task automatic send_beats(input int from, input int to, input int gap);
    for (int b = from; b <= to; b++) send(b == 0, (b % 4) == 3, gap);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pos_x !== 3'd0) begin errors++; $display("FAIL reset_pos_x got=%0d exp=0", pos_x); end
    checks++; if (pos_y !== 2'd0) begin errors++; $display("FAIL reset_pos_y got=%0d exp=0", pos_y); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", frame_count); end
    checks++; if (err_flags !== 5'd0) begin errors++; $display("FAIL reset_err got=%b exp=00000", err_flags); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", frame_done); end
    checks++; if (in_frame !== 1'b0) begin errors++; $display("FAIL reset_in_frame got=%b exp=0", in_frame); end
    vif.tready = 1'b0;
    send(1'b1, 1'b0, 0);
    vif.tready = 1'b1;
    checks++; if (in_frame !== 1'b0) begin errors++; $display("FAIL noready_in_frame got=%b exp=0", in_frame); end
    checks++; if (pos_x !== 3'd0) begin errors++; $display("FAIL noready_pos_x got=%0d exp=0", pos_x); end
  endtask

  task automatic test_clean_frame();
    do_reset();
    base = done_cnt;
    send_beats(0, 0, 0);
    checks++; if (in_frame !== 1'b1) begin errors++; $display("FAIL clean_in_frame got=%b exp=1", in_frame); end
    checks++; if (pos_x !== 3'd2) begin errors++; $display("FAIL clean_sof_x got=%0d exp=2", pos_x); end
    send_beats(1, 3, 0);
    checks++; if (pos_x !== 3'd0 || pos_y !== 2'd1) begin errors++; $display("FAIL clean_eol_pos got=(%0d,%0d) exp=(0,1)", pos_x, pos_y); end
    send_beats(4, 15, 0);
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL clean_done got=%b exp=1", frame_done); end
    checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL clean_count got=%0d exp=1", frame_count); end
    checks++; if (err_flags !== 5'd0) begin errors++; $display("FAIL clean_err got=%b exp=00000", err_flags); end
    checks++; if (in_frame !== 1'b0 || pos_y !== 2'd0) begin errors++; $display("FAIL clean_idle got in_frame=%b y=%0d exp 0,0", in_frame, pos_y); end
`ifdef AXIS_VIDEO_CHECKER_CHECKSUM_EN
    checks++; if (frame_checksum !== 32'h20406080) begin errors++; $display("FAIL clean_csum got=%h exp=20406080", frame_checksum); end
`endif
    idle_cycle();
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL clean_done_pulse got=%b exp=0", frame_done); end
    checks++; if (done_cnt - base !== 1) begin errors++; $display("FAIL clean_done_cnt got=%0d exp=1", done_cnt - base); end
  endtask

  task automatic test_early_eol();
    do_reset();
    base = done_cnt;
    send_beats(0, 5, 0);
    send(1'b0, 1'b1, 0);
    checks++; if (err_flags !== 5'b00001) begin errors++; $display("FAIL eeol_err got=%b exp=00001", err_flags); end
    checks++; if (pos_x !== 3'd0 || pos_y !== 2'd2) begin errors++; $display("FAIL eeol_pos got=(%0d,%0d) exp=(0,2)", pos_x, pos_y); end
    send_beats(8, 15, 0);
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL eeol_done got=%b exp=1", frame_done); end
    checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL eeol_count got=%0d exp=1", frame_count); end
    checks++; if (err_flags !== 5'b00001) begin errors++; $display("FAIL eeol_sticky got=%b exp=00001", err_flags); end
  endtask

  task automatic test_early_sof();
    do_reset();
    base = done_cnt;
    send_beats(0, 9, 0);
    checks++; if (pos_x !== 3'd4 || pos_y !== 2'd2) begin errors++; $display("FAIL esof_pre_pos got=(%0d,%0d) exp=(4,2)", pos_x, pos_y); end
    send_beats(0, 0, 0);
    checks++; if (err_flags !== 5'b00100) begin errors++; $display("FAIL esof_err got=%b exp=00100", err_flags); end
    checks++; if (pos_x !== 3'd2 || pos_y !== 2'd0) begin errors++; $display("FAIL esof_resync_pos got=(%0d,%0d) exp=(2,0)", pos_x, pos_y); end
    checks++; if (frame_count !== 16'd0 || frame_done !== 1'b0) begin errors++; $display("FAIL esof_no_done got cnt=%0d done=%b exp 0,0", frame_count, frame_done); end
    send_beats(1, 15, 0);
    checks++; if (frame_count !== 16'd1 || frame_done !== 1'b1) begin errors++; $display("FAIL esof_done got cnt=%0d done=%b exp 1,1", frame_count, frame_done); end
`ifdef AXIS_VIDEO_CHECKER_CHECKSUM_EN
    checks++; if (frame_checksum !== 32'h20406080) begin errors++; $display("FAIL esof_csum got=%h exp=20406080", frame_checksum); end
`endif
    idle_cycle();
    checks++; if (done_cnt - base !== 1) begin errors++; $display("FAIL esof_done_cnt got=%0d exp=1", done_cnt - base); end
  endtask

  task automatic test_orphan();
    do_reset();
    send(1'b0, 1'b0, 0);
    checks++; if (err_flags !== 5'b01000) begin errors++; $display("FAIL orph_first got=%b exp=01000", err_flags); end
    send(1'b0, 1'b0, 0);
    send(1'b0, 1'b1, 0);
    checks++; if (err_flags !== 5'b11000) begin errors++; $display("FAIL orph_tlast got=%b exp=11000", err_flags); end
    checks++; if (in_frame !== 1'b0 || pos_x !== 3'd0) begin errors++; $display("FAIL orph_idle got in_frame=%b x=%0d exp 0,0", in_frame, pos_x); end
    err_clear = 1'b1;
    idle_cycle();
    err_clear = 1'b0;
    checks++; if (err_flags !== 5'b00000) begin errors++; $display("FAIL orph_clear got=%b exp=00000", err_flags); end
    err_clear = 1'b1;
    send(1'b0, 1'b0, 0);
    err_clear = 1'b0;
    checks++; if (err_flags !== 5'b01000) begin errors++; $display("FAIL orph_clear_vs_new got=%b exp=01000", err_flags); end
    err_clear = 1'b1;
    idle_cycle();
    err_clear = 1'b0;
    checks++; if (err_flags !== 5'b00000) begin errors++; $display("FAIL orph_clear2 got=%b exp=00000", err_flags); end
  endtask

  task automatic test_rst_mid_frame();
    do_reset();
    send_beats(0, 9, 0);
    checks++; if (pos_x !== 3'd4 || pos_y !== 2'd2) begin errors++; $display("FAIL rstm_pre_pos got=(%0d,%0d) exp=(4,2)", pos_x, pos_y); end
    do_reset();
    checks++; if (pos_x !== 3'd0 || pos_y !== 2'd0 || in_frame !== 1'b0) begin errors++; $display("FAIL rstm_pos got=(%0d,%0d) in=%b exp=(0,0) 0", pos_x, pos_y, in_frame); end
    base = done_cnt;
    send_beats(0, 14, 1);
    checks++; if (frame_done !== 1'b0 || frame_count !== 16'd0) begin errors++; $display("FAIL rstm_early got done=%b cnt=%0d exp 0,0", frame_done, frame_count); end
    send_beats(15, 15, 1);
    checks++; if (frame_done !== 1'b1 || frame_count !== 16'd1) begin errors++; $display("FAIL rstm_done got done=%b cnt=%0d exp 1,1", frame_done, frame_count); end
    checks++; if (err_flags !== 5'd0) begin errors++; $display("FAIL rstm_err got=%b exp=00000", err_flags); end
`ifdef AXIS_VIDEO_CHECKER_CHECKSUM_EN
    checks++; if (frame_checksum !== 32'h20406080) begin errors++; $display("FAIL rstm_csum got=%h exp=20406080", frame_checksum); end
`endif
    idle_cycle();
    checks++; if (done_cnt - base !== 1) begin errors++; $display("FAIL rstm_done_cnt got=%0d exp=1", done_cnt - base); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    base = done_cnt;
    send_beats(0, 15, 0);
    checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL b2b_first got=%0d exp=1", frame_count); end
    send_beats(0, 0, 0);
    checks++; if (err_flags !== 5'd0 || in_frame !== 1'b1) begin errors++; $display("FAIL b2b_sof got err=%b in=%b exp 00000,1", err_flags, in_frame); end
    send_beats(1, 15, 0);
    checks++; if (frame_count !== 16'd2 || frame_done !== 1'b1) begin errors++; $display("FAIL b2b_second got cnt=%0d done=%b exp 2,1", frame_count, frame_done); end
    idle_cycle();
    checks++; if (done_cnt - base !== 2) begin errors++; $display("FAIL b2b_done_cnt got=%0d exp=2", done_cnt - base); end
  endtask

  initial begin
    vif.tvalid = 1'b0;
    vif.tready = 1'b1;
    vif.tlast  = 1'b0;
    vif.tuser  = 1'b0;
    vif.tdata  = '0;
    idle_cycle();
    test_reset();
    test_clean_frame();
    test_early_eol();
    test_early_sof();
    test_orphan();
    test_rst_mid_frame();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
